// File: rtl/life_sequencer.sv
// life_sequencer: owns the 8x8 Life grid register and paces the evolve datapath.
// Ports: clk/rst_n; load_valid/load_grid/load_ready load handshake;
//   cmd_run/cmd_step/cmd_pause commands; period ticks per generation;
//   halt_on_stable auto-halt enable; dp_grid/dp_evolve datapath loop;
//   gen_count/gen_pulse/stable/extinct status; state (0 IDLE, 1 RUN, 2 HALT).
module life_sequencer #(
  parameter int GRID_W = 64,
  parameter int TICK_W = 24,
  parameter int GEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  input  logic [GRID_W-1:0] load_grid,
  output logic              load_ready,
  input  logic              cmd_run,
  input  logic              cmd_step,
  input  logic              cmd_pause,
  input  logic [TICK_W-1:0] period,
  input  logic              halt_on_stable,
  output logic [GRID_W-1:0] dp_grid,
  input  logic [GRID_W-1:0] dp_evolve,
  output logic [GEN_W-1:0]  gen_count,
  output logic              gen_pulse,
  output logic              stable,
  output logic              extinct,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [GRID_W-1:0]   grid_q;
  logic [GEN_W-1:0]    gen_q;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic                pulse_q, stable_q;

  logic                load_acc;
  logic                do_load, do_commit;
  logic                same;
  logic                tick_hit;
  logic [TICK_W-1:0]   period_m1;

  assign load_ready = (state_q == S_IDLE) || (state_q == S_HALT);
  assign load_acc   = load_valid && load_ready;
  assign same       = (dp_evolve == grid_q);

  // period 0 behaves like 1; >= lets a lowered period fire immediately
  assign period_m1 = (period == '0) ? '0 : period - 1'b1;
  assign tick_hit  = (tick_q >= period_m1);

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    do_load   = 1'b0;
    do_commit = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (load_acc) begin
          do_load = 1'b1;
        end else if (cmd_pause) begin
          state_d = S_IDLE;
        end else if (cmd_step) begin
          do_commit = 1'b1;
        end else if (cmd_run) begin
          state_d = S_RUN;
          tick_d  = '0;
        end
      end
      S_RUN: begin
        if (cmd_pause) begin
          state_d = S_IDLE;
          tick_d  = '0;
        end else if (tick_hit) begin
          do_commit = 1'b1;
          tick_d    = '0;
          if (same && halt_on_stable)
            state_d = S_HALT;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      S_HALT: begin
        if (load_acc) begin
          do_load = 1'b1;
          state_d = S_IDLE;
        end else if (cmd_pause) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      grid_q   <= '0;
      gen_q    <= '0;
      tick_q   <= '0;
      pulse_q  <= 1'b0;
      stable_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      pulse_q <= do_commit;
      if (do_load) begin
        grid_q   <= load_grid;
        gen_q    <= '0;
        stable_q <= 1'b0;
      end else if (do_commit) begin
        grid_q   <= dp_evolve;
        gen_q    <= (&gen_q) ? gen_q : gen_q + 1'b1;
        stable_q <= same;
      end
    end
  end

  assign dp_grid   = grid_q;
  assign gen_count = gen_q;
  assign gen_pulse = pulse_q;
  assign stable    = stable_q;
  assign extinct   = (grid_q == '0);
  assign state     = state_q;

endmodule

// File: tb/tb_life_sequencer.sv
// tb_life_sequencer: vector table, corner sequences and random run
// against a behavioural model of the sequencer and an ideal Life datapath.
module tb_life_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic [63:0] load_grid = '0;
  logic        cmd_run = 1'b0, cmd_step = 1'b0, cmd_pause = 1'b0;
  logic [23:0] period = 24'd1;
  logic        halt_on_stable = 1'b0;

  logic        load_ready, gen_pulse, stable, extinct;
  logic [63:0] dp_grid, dp_evolve;
  logic [15:0] gen_count;
  logic [1:0]  state;

  logic        lr4, gp4, st4, ex4;
  logic [63:0] dg4, de4;
  logic [3:0]  gc4;
  logic [1:0]  s4;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  function automatic logic [63:0] life(input logic [63:0] g);
    logic [63:0] n;
    n = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        int k;
        k = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (!(dr == 0 && dc == 0) && r + dr >= 0 && r + dr < 8 &&
                c + dc >= 0 && c + dc < 8 && g[(r + dr) * 8 + c + dc])
              k++;
        n[r * 8 + c] = (k == 3) || (g[r * 8 + c] && k == 2);
      end
    return n;
  endfunction

  always_comb dp_evolve = life(dp_grid);
  always_comb de4 = life(dg4);

  life_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid), .load_grid(load_grid),
    .load_ready(load_ready),
    .cmd_run(cmd_run), .cmd_step(cmd_step), .cmd_pause(cmd_pause),
    .period(period), .halt_on_stable(halt_on_stable),
    .dp_grid(dp_grid), .dp_evolve(dp_evolve),
    .gen_count(gen_count), .gen_pulse(gen_pulse),
    .stable(stable), .extinct(extinct), .state(state)
  );

  life_sequencer #(.GEN_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid), .load_grid(load_grid),
    .load_ready(lr4),
    .cmd_run(cmd_run), .cmd_step(cmd_step), .cmd_pause(cmd_pause),
    .period(period), .halt_on_stable(halt_on_stable),
    .dp_grid(dg4), .dp_evolve(de4),
    .gen_count(gc4), .gen_pulse(gp4),
    .stable(st4), .extinct(ex4), .state(s4)
  );

  // behavioural model: 0 idle, 1 run, 2 halt
  int          m_state;
  logic [63:0] m_grid;
  int          m_gen;
  int          m_wait;
  bit          m_pulse, m_stable;

  task automatic m_reset();
    m_state = 0; m_grid = '0; m_gen = 0;
    m_wait = 0; m_pulse = 0; m_stable = 0;
  endtask

  task automatic m_commit();
    logic [63:0] nx;
    nx = life(m_grid);
    m_stable = (nx == m_grid);
    m_grid = nx;
    if (m_gen < 65535) m_gen++;
    m_pulse = 1;
  endtask

  task automatic m_step();
    int pe;
    m_pulse = 0;
    pe = (period == 0) ? 1 : int'(period);
    case (m_state)
      0: begin
        if (load_valid) begin
          m_grid = load_grid; m_gen = 0; m_stable = 0;
        end else if (cmd_pause) begin
        end else if (cmd_step) m_commit();
        else if (cmd_run) begin
          m_state = 1; m_wait = 0;
        end
      end
      1: begin
        if (cmd_pause) begin
          m_state = 0; m_wait = 0;
        end else if (m_wait + 1 >= pe) begin
          m_wait = 0;
          m_commit();
          if (m_stable && halt_on_stable) m_state = 2;
        end else m_wait++;
      end
      default: begin
        if (load_valid) begin
          m_grid = load_grid; m_gen = 0; m_stable = 0; m_state = 0;
        end else if (cmd_pause) m_state = 0;
      end
    endcase
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic check_all();
    chk("state", 64'(state), 64'(m_state));
    chk("grid", dp_grid, m_grid);
    chk("gen", 64'(gen_count), 64'(m_gen));
    chk("pulse", 64'(gen_pulse), 64'(m_pulse));
    chk("stable", 64'(stable), 64'(m_stable));
    chk("extinct", 64'(extinct), 64'(m_grid == 0));
    chk("load_ready", 64'(load_ready), 64'(m_state != 1));
    chk("gen4", 64'(gc4), 64'((m_gen > 15) ? 15 : m_gen));
  endtask

  task automatic cycle();
    @(posedge clk);
    m_step();
    #1;
    check_all();
  endtask

  task automatic idle_in();
    load_valid = 0; cmd_run = 0; cmd_step = 0; cmd_pause = 0;
  endtask

  typedef struct {
    logic        lv;
    logic [63:0] lg;
    logic        run, step, pause;
    logic [23:0] per;
    logic        hos;
    logic [1:0]  e_state;
    logic [63:0] e_grid;
    logic [15:0] e_gen;
    logic        e_pulse, e_stable;
  } vec_t;

  function automatic vec_t mk(
    logic lv, logic [63:0] lg, logic run, logic step, logic pause,
    logic [23:0] per, logic hos, logic [1:0] es, logic [63:0] eg,
    logic [15:0] en, logic ep, logic est);
    vec_t v;
    v.lv = lv; v.lg = lg; v.run = run; v.step = step; v.pause = pause;
    v.per = per; v.hos = hos; v.e_state = es; v.e_grid = eg;
    v.e_gen = en; v.e_pulse = ep; v.e_stable = est;
    return v;
  endfunction

  localparam logic [63:0] HB = 64'h0000_0000_1C00_0000;
  localparam logic [63:0] VB = 64'h0000_0008_0808_0000;
  localparam logic [63:0] BK = 64'h0000_0018_1800_0000;
  localparam logic [63:0] F1 = 64'hFFFF_FFFF_FFFF_FFFF;

  vec_t tbl[20];

  initial begin
    tbl[0]  = mk(1, HB, 0, 0, 0, 1, 0, 0, HB, 0, 0, 0);
    tbl[1]  = mk(0, 0,  1, 1, 0, 1, 0, 0, VB, 1, 1, 0);
    tbl[2]  = mk(1, HB, 0, 1, 0, 1, 0, 0, HB, 0, 0, 0);
    tbl[3]  = mk(0, 0,  0, 0, 0, 1, 0, 0, HB, 0, 0, 0);
    tbl[4]  = mk(0, 0,  1, 0, 0, 1, 0, 1, HB, 0, 0, 0);
    tbl[5]  = mk(0, 0,  0, 0, 0, 1, 0, 1, VB, 1, 1, 0);
    tbl[6]  = mk(0, 0,  0, 0, 0, 1, 0, 1, HB, 2, 1, 0);
    tbl[7]  = mk(0, 0,  0, 0, 0, 1, 0, 1, VB, 3, 1, 0);
    tbl[8]  = mk(1, F1, 0, 0, 0, 1, 0, 1, HB, 4, 1, 0);
    tbl[9]  = mk(0, 0,  0, 0, 1, 1, 0, 0, HB, 4, 0, 0);
    tbl[10] = mk(0, 0,  0, 0, 0, 1, 0, 0, HB, 4, 0, 0);
    tbl[11] = mk(1, BK, 0, 0, 0, 4, 1, 0, BK, 0, 0, 0);
    tbl[12] = mk(0, 0,  1, 0, 0, 4, 1, 1, BK, 0, 0, 0);
    tbl[13] = mk(0, 0,  0, 0, 0, 4, 1, 1, BK, 0, 0, 0);
    tbl[14] = mk(0, 0,  0, 0, 0, 4, 1, 1, BK, 0, 0, 0);
    tbl[15] = mk(0, 0,  0, 0, 0, 4, 1, 1, BK, 0, 0, 0);
    tbl[16] = mk(0, 0,  0, 0, 0, 4, 1, 2, BK, 1, 1, 1);
    tbl[17] = mk(0, 0,  0, 0, 0, 4, 1, 2, BK, 1, 0, 1);
    tbl[18] = mk(0, 0,  1, 1, 0, 4, 1, 2, BK, 1, 0, 1);
    tbl[19] = mk(0, 0,  0, 0, 1, 4, 1, 0, BK, 1, 0, 1);

    m_reset();
    #2;
    check_all();
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // table vectors
    for (int i = 0; i < 20; i++) begin
      load_valid = tbl[i].lv; load_grid = tbl[i].lg;
      cmd_run = tbl[i].run; cmd_step = tbl[i].step;
      cmd_pause = tbl[i].pause; period = tbl[i].per;
      halt_on_stable = tbl[i].hos;
      cycle();
      chk($sformatf("v%0d.state", i), 64'(state), 64'(tbl[i].e_state));
      chk($sformatf("v%0d.grid", i), dp_grid, tbl[i].e_grid);
      chk($sformatf("v%0d.gen", i), 64'(gen_count), 64'(tbl[i].e_gen));
      chk($sformatf("v%0d.pulse", i), 64'(gen_pulse), 64'(tbl[i].e_pulse));
      chk($sformatf("v%0d.stable", i), 64'(stable), 64'(tbl[i].e_stable));
    end
    idle_in();

    // live period change: period 10, drop to 3 at count 6
    halt_on_stable = 0; period = 24'd10;
    load_valid = 1; load_grid = HB; cycle(); idle_in();
    cmd_run = 1; cycle(); cmd_run = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("per.nopulse", 64'(gen_pulse), 64'd0);
    end
    period = 24'd3;
    cycle();
    chk("per.commit", 64'(gen_pulse), 64'd1);
    chk("per.grid", dp_grid, VB);

    // saturation in the 4-bit build; the 16-bit build keeps counting
    period = 24'd1;
    for (int i = 0; i < 20; i++) cycle();
    chk("sat.gen4", 64'(gc4), 64'd15);
    chk("sat.gen16", 64'(gen_count), 64'd21);

    // asynchronous reset mid-RUN
    #3 rst_n = 1'b0;
    #1;
    m_reset();
    chk("rst.state", 64'(state), 64'd0);
    chk("rst.grid", dp_grid, 64'd0);
    chk("rst.extinct", 64'(extinct), 64'd1);
    chk("rst.gen", 64'(gen_count), 64'd0);
    @(posedge clk); #1;
    check_all();
    #2 rst_n = 1'b1;
    cycle();
    chk("rst.nocommit", 64'(gen_pulse), 64'd0);

    // randomized run against the model
    for (int i = 0; i < 400; i++) begin
      int r;
      idle_in();
      r = int'($urandom_range(0, 99));
      if (r < 6) begin
        load_valid = 1;
        load_grid = {$urandom, $urandom} & {$urandom, $urandom};
      end
      if (r >= 6 && r < 10) cmd_run = 1;
      if (r >= 10 && r < 13) cmd_step = 1;
      if (r >= 13 && r < 15) cmd_pause = 1;
      if ($urandom_range(0, 19) == 0) begin
        cmd_run = 1; cmd_step = 1; cmd_pause = $urandom_range(0, 1) == 1;
      end
      if ($urandom_range(0, 15) == 0) period = 24'($urandom_range(0, 5));
      if ($urandom_range(0, 31) == 0) halt_on_stable = ~halt_on_stable;
      cycle();
    end
    idle_in();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/life_sequencer.md
Name: life_sequencer

Overview:
Controller that owns the 8x8 Game of Life state register and sequences the combinational evolve datapath. It accepts pattern loads and run/step/pause commands, and commits one generation per programmable tick period. It also counts generations and flags still-life and extinct grids, with optional auto-halt. It sits between the host/control logic and the datapath: `dp_grid` feeds the datapath input, and `dp_evolve` is the datapath output.

Parameters:
- `GRID_W`, 64, grid bit count; bit index = row*8+col.
- `TICK_W`, 24, width of the period input and internal tick counter.
- `GEN_W`, 16, width of the generation counter.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `load_valid`  in  1  load request for `load_grid`.
- `load_grid`  in  GRID_W  pattern to load.
- `load_ready`  out  1  high when a load will be accepted (IDLE or HALT).
- `cmd_run`  in  1  start continuous evolution.
- `cmd_step`  in  1  single-generation step.
- `cmd_pause`  in  1  stop evolution / leave HALT.
- `period`  in  TICK_W  clock cycles per generation in RUN; value 0 is treated as 1.
- `halt_on_stable`  in  1  enables auto-halt when the grid stops changing.
- `dp_grid`  out  GRID_W  current grid register, drives the datapath input.
- `dp_evolve`  in  GRID_W  next generation from the datapath (combinational).
- `gen_count`  out  GEN_W  generations committed since the last load; saturating.
- `gen_pulse`  out  1  one-cycle pulse on every commit.
- `stable`  out  1  last commit produced no change.
- `extinct`  out  1  `dp_grid == 0`, combinational.
- `state`  out  2  0=IDLE, 1=RUN, 2=HALT.

Behaviour:
- Reset (async, immediate, any state): state=IDLE; `dp_grid`=0; `gen_count`=0; tick counter=0; `gen_pulse`=0; `stable`=0. `load_ready`=1 and `extinct`=1 follow from this.
- Commit (one clock edge): `dp_grid`<=`dp_evolve`; `gen_count`+=1, holding at all-ones; `gen_pulse`=1 for exactly that next cycle; `stable`<=(`dp_evolve`==`dp_grid`).
- Command priority when several are high in one cycle: `load_valid` (if accepted) > `cmd_pause` > `cmd_step` > `cmd_run`.
- IDLE:
  - `load_valid` → `dp_grid`<=`load_grid`, `gen_count`<=0, `stable`<=0, no commit.
  - `cmd_step` → commit at this edge; stay IDLE.
  - `cmd_run` → RUN; tick counter<=0.
  - `cmd_pause` → no effect.
- RUN:
  - Tick counter increments every cycle.
  - When counter >= max(`period`,1)-1: commit and counter<=0.
  - First commit occurs `period` cycles after the RUN entry edge; `period`=1 commits every cycle.
  - `period` is sampled live. Lowering it below the current count causes a commit on the next cycle; the counter never wraps.
  - `cmd_pause` → IDLE with no commit that edge; counter cleared.
  - `cmd_step` and `cmd_run` are ignored.
  - `load_valid` is ignored; `load_ready`=0.
  - On commit with `dp_evolve`==`dp_grid` and `halt_on_stable`=1 → HALT (the commit itself still happens).
- HALT:
  - No commits.
  - `load_valid` → load as in IDLE, state → IDLE.
  - `cmd_pause` → IDLE, `stable` held.
  - `cmd_run` and `cmd_step` are ignored.
- `stable` persists until the next commit or load.
- `extinct` needs no special handling: an all-zero grid evolves to zero, so the following commit sets `stable` and auto-halt applies.
- `dp_grid` changes only on load, commit or reset. There is no combinational path from `dp_evolve` to any output except through the register.
- The bench connects an ideal 8x8 Life model with dead (non-wrapping) borders to `dp_evolve`.

Test Plan:
- Blinker:
  - Stimulus: load 64'h0000_0000_1C00_0000; `period`=1; `cmd_run` for 1 cycle.
  - Response: `dp_grid` alternates 64'h0000_0008_0808_0000 / 64'h0000_0000_1C00_0000 every cycle, `gen_pulse` high each cycle, `gen_count` 1,2,3…, `stable`=0.
- Block still life with halt:
  - Stimulus: load 64'h0000_0018_1800_0000; `halt_on_stable`=1; `period`=4; run.
  - Response: single commit 4 cycles after RUN entry, `stable`=1, `state`=HALT, `gen_count`=1, grid unchanged.
- Step and priority:
  - Stimulus: in IDLE, assert `cmd_step` and `cmd_run` together on the blinker pattern.
  - Response: exactly one commit, `state` stays IDLE, `gen_count`=1.
  - Stimulus: `load_valid`+`cmd_step` together.
  - Response: load wins, `gen_count`=0.
- Load/pause in RUN:
  - Stimulus: `load_valid` with 64'hFFFF_FFFF_FFFF_FFFF during RUN.
  - Response: ignored, `load_ready`=0.
  - Stimulus: `cmd_pause`.
  - Response: IDLE next cycle, no further `gen_pulse`.
- Period change and saturation:
  - Stimulus: RUN with `period`=10; at count 6 set `period`=3.
  - Response: commit on the next cycle.
  - Stimulus: `GEN_W`=4 build, blinker with `period`=1 for 20 cycles.
  - Response: `gen_count` stays at 15.
- Reset mid-RUN:
  - Stimulus: drop `rst_n` asynchronously between clock edges.
  - Response: outputs clear immediately: `state`=IDLE, `dp_grid`=0, `extinct`=1, `gen_count`=0. No commit on the first edge after release.
